// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// Module      : mdu_seq
// Description : EXE-stage multiply/divide sequencer. Stalls the pipeline,
//               drives the divider IP handshake and issues one HI/LO write.
//               Optional macro MDU_MUL_PIPE_EN splits the multiply in two.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_seq #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op_kind,
    input  logic [31:0] op_src1,
    input  logic [31:0] op_src2,
    input  logic        flush,
    input  logic        ms_allowin,
    output logic        es_stop,
    output logic        div_tvalid,
    output logic        divu_tvalid,
    output logic [31:0] div_src1,
    output logic [31:0] div_src2,
    input  logic        div_dout_tvalid,
    input  logic [63:0] div_dout_tdata,
    input  logic        divu_dout_tvalid,
    input  logic [63:0] divu_dout_tdata,
    output logic [1:0]  hl_we,
    output logic [31:0] h_wdata,
    output logic [31:0] l_wdata,
    output logic        done,
    output logic        busy,
    output logic        err_timeout
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_MUL       = 3'd1;
    localparam logic [2:0] c_DIV_ISSUE = 3'd3;
    localparam logic [2:0] c_DIV_WAIT  = 3'd4;
    localparam logic [2:0] c_DONE      = 3'd5;
`ifdef MDU_MUL_PIPE_EN
    localparam logic [2:0] c_MUL2      = 3'd2;
    localparam logic [2:0] c_MUL_NEXT  = c_MUL2;
`else
    localparam logic [2:0] c_MUL_NEXT  = c_DONE;
`endif

    logic [2:0]         r_state;
    logic               r_uns;
    logic [31:0]        r_src1;
    logic [31:0]        r_src2;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_drain;
    logic               r_err;
    logic               r_first;
    logic               r_wr;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic [2:0]  w_next;
    logic        w_accept;
    logic        w_resp;
    logic        w_any_dout;
    logic        w_es_stop;
    logic        w_wr;
    logic        w_set_drain;
    logic        w_set_err;
    logic        w_capture;
    logic        w_done;
    logic [63:0] w_div_data;
    logic [63:0] w_a64;
    logic [63:0] w_b64;

    // A div waiting behind a stale in-flight response must not be issued.
    assign w_accept   = (r_state == c_IDLE) & op_valid & ~flush & ~(r_drain & op_kind[1]);
    assign w_resp     = r_uns ? divu_dout_tvalid : div_dout_tvalid;
    assign w_any_dout = div_dout_tvalid | divu_dout_tvalid;
    assign w_div_data = r_uns ? divu_dout_tdata : div_dout_tdata;

    // Sign/zero extension lets one 64-bit product serve both MULT and MULTU.
    assign w_a64 = {{32{~r_uns & r_src1[31]}}, r_src1};
    assign w_b64 = {{32{~r_uns & r_src2[31]}}, r_src2};

    always_comb begin
        w_next      = r_state;
        w_es_stop   = 1'b0;
        w_wr        = 1'b0;
        w_set_drain = 1'b0;
        w_set_err   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_es_stop = op_valid & ~flush;
                if (w_accept) begin
                    if (!op_kind[1])
                        w_next = c_MUL;
                    else if (op_src2 == 32'd0)
                        w_next = c_DONE;
                    else
                        w_next = c_DIV_ISSUE;
                end
            end
            c_MUL: begin
                w_es_stop = 1'b1;
                w_wr      = 1'b1;
                w_next    = flush ? c_IDLE : c_MUL_NEXT;
            end
`ifdef MDU_MUL_PIPE_EN
            c_MUL2: begin
                w_es_stop = 1'b1;
                w_wr      = 1'b1;
                w_next    = flush ? c_IDLE : c_DONE;
            end
`endif
            c_DIV_ISSUE: begin
                // The IP already saw tvalid, so a flush here leaves a response in flight.
                w_es_stop   = 1'b1;
                w_set_drain = flush;
                w_next      = flush ? c_IDLE : c_DIV_WAIT;
            end
            c_DIV_WAIT: begin
                w_es_stop = 1'b1;
                if (flush) begin
                    w_set_drain = ~w_resp;
                    w_next      = c_IDLE;
                end else if (w_resp) begin
                    w_wr      = 1'b1;
                    w_capture = 1'b1;
                    w_next    = c_DONE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_set_err   = 1'b1;
                    w_set_drain = 1'b1;
                    w_next      = c_DONE;
                end
            end
            c_DONE: begin
                if (ms_allowin)
                    w_next = c_IDLE;
            end
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_uns   <= 1'b0;
            r_src1  <= 32'd0;
            r_src2  <= 32'd0;
            r_cnt   <= '0;
            r_drain <= 1'b0;
            r_err   <= 1'b0;
            r_first <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_uns  <= op_kind[0];
                r_src1 <= op_src1;
                r_src2 <= op_src2;
            end
            r_cnt <= (r_state == c_DIV_WAIT) ? r_cnt + 1'b1 : '0;
            if (w_set_drain)
                r_drain <= 1'b1;
            else if (w_any_dout)
                r_drain <= 1'b0;
            if (w_set_err)
                r_err <= 1'b1;
            r_first <= (w_next == c_DONE) && (r_state != c_DONE);
            if ((w_next == c_DONE) && (r_state != c_DONE))
                r_wr <= w_wr;
        end
    end

`ifdef MDU_MUL_PIPE_EN
    logic [63:0] r_pp_lo;
    logic [47:0] r_pp_hi;
    logic [63:0] w_pp_lo;
    logic [47:0] w_pp_hi;

    // Only the low 48 bits of the upper partial product survive the 16-bit shift.
    assign w_pp_lo = w_a64 * {48'd0, w_b64[15:0]};
    assign w_pp_hi = w_a64[47:0] * w_b64[63:16];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pp_lo <= 64'd0;
            r_pp_hi <= 48'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            if (r_state == c_MUL) begin
                r_pp_lo <= w_pp_lo;
                r_pp_hi <= w_pp_hi;
            end
            if (r_state == c_MUL2)
                {r_hi, r_lo} <= r_pp_lo + {r_pp_hi, 16'd0};
            else if (w_capture)
                {r_hi, r_lo} <= {w_div_data[31:0], w_div_data[63:32]};
        end
    end
`else
    logic [63:0] w_prod;

    assign w_prod = w_a64 * w_b64;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (r_state == c_MUL)
                {r_hi, r_lo} <= w_prod;
            else if (w_capture)
                {r_hi, r_lo} <= {w_div_data[31:0], w_div_data[63:32]};
        end
    end
`endif

    assign w_done      = (r_state == c_DONE) & r_first;
    assign done        = w_done;
    assign hl_we       = {2{w_done & r_wr}};
    assign es_stop     = w_es_stop;
    assign busy        = (r_state != c_IDLE);
    assign err_timeout = r_err;
    assign div_tvalid  = (r_state == c_DIV_ISSUE) & ~r_uns;
    assign divu_tvalid = (r_state == c_DIV_ISSUE) & r_uns;
    assign div_src1    = r_src1;
    assign div_src2    = r_src2;
    assign h_wdata     = r_hi;
    assign l_wdata     = r_lo;

endmodule
`default_nettype wire
